// File: rtl/ddc_ring_reader.sv
// Drains the DDC {I,Q} sample ring in BURST_LEN-sample bursts onto AXI4-Stream (tlast per burst).
// Latency: RAM data 1 cycle after address; first tvalid 2 cycles after entering BURST.
// Backpressure: 2-entry skid buffer, reads stall while it would overfill; DDC_RD_IQ_SWAP_EN emits {Q,I}.
module ddc_ring_reader #(
    parameter int          U_DLY     = 1,
    parameter logic [13:0] MAX_ADDR  = 14'd11520,
    parameter int          BURST_LEN = 64,
    parameter logic [13:0] OVF_LEVEL = 14'd11000
) (
    input  logic        axis_clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [13:0] ram_waddr,
    output logic [13:0] ram_raddr,
    input  logic [31:0] ram_rdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [13:0] fill_level,
    output logic [15:0] ovf_cnt,
    output logic        busy
);

    if (BURST_LEN < 2 || BURST_LEN > 1024 || U_DLY < 0) begin : g_cfg_check
        $error("ddc_ring_reader: BURST_LEN must be within 2..1024");
    end

    localparam logic [10:0] BL         = 11'(BURST_LEN);
    localparam logic [10:0] BL_M1      = 11'(BURST_LEN - 1);
    localparam logic [13:0] FILL_BURST = 14'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DRAIN,
        S_RESYNC
    } state_t;

    state_t      state;
    logic [13:0] rd_ptr;
    logic [13:0] rd_ptr_inc;
    logic [10:0] issued;
    logic        settle;
    logic        rd_inflight;
    logic        rd_inflight_last;
    logic        skid_vld;
    logic        skid_last;
    logic [31:0] skid_dat;
    logic [31:0] push_dat;
    logic        pop;
    logic        issue;
    logic        issue_last;
    logic [2:0]  lvl_after;
    logic [14:0] fill_wrap;

    assign ram_raddr = rd_ptr;

`ifdef DDC_RD_IQ_SWAP_EN
    assign push_dat = {ram_rdata[15:0], ram_rdata[31:16]};
`else
    assign push_dat = ram_rdata;
`endif

    assign pop        = m_axis_tvalid & m_axis_tready;
    // Entries held after this cycle: skid occupancy plus the read already in flight.
    assign lvl_after  = 3'(m_axis_tvalid) + 3'(skid_vld) + 3'(rd_inflight) - 3'(pop);
    assign issue      = (state == S_BURST) && (issued < BL) && (lvl_after <= 3'd1)
                        && (fill_level != 14'd0);
    assign issue_last = (issued == BL_M1);
    assign rd_ptr_inc = (rd_ptr == MAX_ADDR) ? 14'd0 : rd_ptr + 14'd1;
    assign fill_wrap  = {1'b0, ram_waddr} + {1'b0, MAX_ADDR} + 15'd1 - {1'b0, rd_ptr};

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_ptr     <= 14'd0;
            issued     <= 11'd0;
            ovf_cnt    <= 16'd0;
            busy       <= 1'b0;
            settle     <= 1'b0;
            fill_level <= 14'd0;
        end else begin
            fill_level <= (ram_waddr >= rd_ptr) ? ram_waddr - rd_ptr : fill_wrap[13:0];
            settle     <= 1'b0;
            if (issue) begin
                rd_ptr <= rd_ptr_inc;
                issued <= issued + 11'd1;
            end
            case (state)
                S_IDLE: begin
                    if (enb) state <= S_WAIT;
                end
                S_WAIT: begin
                    // The cycle after a resync still shows the pre-resync fill level; skip it.
                    if (!enb) begin
                        state <= S_IDLE;
                    end else if (!settle) begin
                        if (fill_level >= OVF_LEVEL) begin
                            state <= S_RESYNC;
                        end else if (fill_level >= FILL_BURST) begin
                            state  <= S_BURST;
                            issued <= 11'd0;
                            busy   <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (issue && issue_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        state <= S_WAIT;
                        busy  <= 1'b0;
                    end
                end
                S_RESYNC: begin
                    rd_ptr <= ram_waddr;
                    if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
                    settle <= 1'b1;
                    state  <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output register is the skid head; the second entry only fills while the head is stalled.
    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            rd_inflight      <= 1'b0;
            rd_inflight_last <= 1'b0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata     <= 32'd0;
            m_axis_tlast     <= 1'b0;
            skid_vld         <= 1'b0;
            skid_dat         <= 32'd0;
            skid_last        <= 1'b0;
        end else begin
            rd_inflight      <= issue;
            rd_inflight_last <= issue & issue_last;
            if (pop || !m_axis_tvalid) begin
                if (skid_vld) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= skid_dat;
                    m_axis_tlast  <= skid_last;
                    skid_vld      <= rd_inflight;
                    skid_dat      <= push_dat;
                    skid_last     <= rd_inflight_last;
                end else begin
                    m_axis_tvalid <= rd_inflight;
                    m_axis_tlast  <= rd_inflight_last;
                    if (rd_inflight) m_axis_tdata <= push_dat;
                end
            end else if (rd_inflight) begin
                skid_vld  <= 1'b1;
                skid_dat  <= push_dat;
                skid_last <= rd_inflight_last;
            end
        end
    end

endmodule
